// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the program counter, requests memory reads,
// strobes the IR load, and hands each instruction to execute with start/done.
module fetch_sequencer #(
  parameter int                   AddrWidth    = 24,
  parameter logic [AddrWidth-1:0] ResetVector  = '0,
  parameter int                   MaxWait      = 15,
  parameter int                   WaitCntWidth = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Run,
  input  logic                 MemAck,
  input  logic                 ExecDone,
  input  logic                 BranchTaken,
  input  logic [AddrWidth-1:0] BranchAddr,
  output logic                 MemReq,
  output logic [AddrWidth-1:0] MemAddr,
  output logic                 IRInEn,
  output logic                 ExecStart,
  output logic [AddrWidth-1:0] PCOut,
  output logic                 BusError,
  output logic [2:0]           StateOut
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_EXEC  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [AddrWidth-1:0]    pc_q, pc_d;
  logic [WaitCntWidth-1:0] wait_q, wait_d;

  // NOTE: reset is asynchronous, so it sits in the sensitivity list and wins
  // immediately, abandoning any fetch or execute in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= ResetVector;
      wait_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments up front keep this block free of latches.
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Run) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (MemAck) begin
          // An ack on the last allowed wait cycle still wins over the timeout.
          pc_d    = pc_q + AddrWidth'(1);
          wait_d  = '0;
          state_d = ST_START;
        end else begin
          wait_d = wait_q + WaitCntWidth'(1);
          if (wait_d == WaitCntWidth'(MaxWait)) state_d = ST_ERROR;
        end
      end

      ST_START: begin
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        if (ExecDone) begin
          if (BranchTaken) pc_d = BranchAddr;
          state_d = Run ? ST_FETCH : ST_IDLE;
        end
      end

      ST_ERROR: begin
        state_d = ST_ERROR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Everything except IRInEn is a pure decode of registered state.
  assign MemReq    = (state_q == ST_FETCH);
  assign IRInEn    = (state_q == ST_FETCH) && MemAck;
  assign ExecStart = (state_q == ST_START);
  assign BusError  = (state_q == ST_ERROR);
  assign StateOut  = state_q;
  assign PCOut     = pc_q;
  assign MemAddr   = pc_q;

endmodule
